// File: rtl/rtc_timer_pkg.sv
// rtc_timer_pkg: shared constants for the real-time clock peripheral.
//   - register offsets within the 16-byte window (addr[3:0])
//   - per-field upper limits used by the write range guard
//   - bit positions inside the CTRL register
package rtc_timer_pkg;

  localparam logic [3:0] RTC_HOUR     = 4'd0;
  localparam logic [3:0] RTC_MIN      = 4'd1;
  localparam logic [3:0] RTC_SEC      = 4'd2;
  localparam logic [3:0] RTC_ALM_HOUR = 4'd3;
  localparam logic [3:0] RTC_ALM_MIN  = 4'd4;
  localparam logic [3:0] RTC_CTRL     = 4'd5;

  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] SEC_MAX  = 8'd59;

  localparam int CTRL_RUN_BIT      = 0;
  localparam int CTRL_ALM_EN_BIT   = 1;
  localparam int CTRL_ALM_FLAG_BIT = 2;

  // True when a CPU write value fits within the field limit.
  function automatic logic in_range(input logic [7:0] value, input logic [7:0] limit);
    return (value <= limit);
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides the bus clock down to a one-second tick.
//   clock : rising-edge clock
//   rst   : asynchronous active-high reset (counter -> 0)
//   en    : count enable; the counter holds its value while low
//   clr   : synchronous clear of the counter (wins over counting)
//   tick  : combinational, high in the cycle the counter sits at CLK_FREQ-1
//           while enabled; the counter wraps to 0 on that edge
module rtc_prescaler #(
  parameter int CLK_FREQ = 10000000
) (
  input  logic clock,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] pcnt_r;

  // With CLK_FREQ = 1 the counter is stuck at 0 == PCNT_LAST, so it ticks every cycle.
  assign tick = en && (pcnt_r == PCNT_LAST);

  // Prescale counter: clear, wrap on tick, advance while enabled, else hold.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pcnt_r <= '0;
    end else if (clr) begin
      pcnt_r <= '0;
    end else if (tick) begin
      pcnt_r <= '0;
    end else if (en) begin
      pcnt_r <= pcnt_r + PW'(1);
    end else begin
      pcnt_r <= pcnt_r;
    end
  end

endmodule

// File: rtl/rtc_timer.sv
// rtc_timer: 24-hour hh:mm:ss real-time clock with a CPU register window.
// Optional alarm compiled in with `define RTC_TIMER_ALARM_EN.
//   clock, rst        : clock (rising edge) and asynchronous active-high reset
//   w_en_n, r_en_n    : active-low CPU write / read strobes
//   addr[15:0]        : addr[7:4] == BASE_NIB selects block, addr[3:0] = register
//   wdata[7:0]        : write data
//   rdata[7:0]        : registered read data, held between reads
//   hour/minute/second: current time
//   sec_tick          : one-cycle pulse in the cycle a new second first shows
//   alarm_irq         : one-cycle alarm pulse (constant 0 without the alarm)
module rtc_timer
  import rtc_timer_pkg::*;
#(
  parameter int         CLK_FREQ = 10000000,
  parameter logic [3:0] BASE_NIB = 4'h8
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        w_en_n,
  input  logic        r_en_n,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic [4:0]  hour,
  output logic [5:0]  minute,
  output logic [5:0]  second,
  output logic        sec_tick,
  output logic        alarm_irq
);

  logic       sel_s, wr_s, rd_s, tick_s;
  logic [3:0] off_s;
  logic       hour_wr_s, min_wr_s, sec_wr_s, ctrl_wr_s;
  logic [4:0] hour_nxt_s;
  logic [5:0] minute_nxt_s, second_nxt_s;
  logic [7:0] rd_val_s;
  logic       unused_s;

  logic [4:0] hour_r;
  logic [5:0] minute_r, second_r;
  logic       run_r, sec_tick_r;
  logic [7:0] rdata_r;

  assign sel_s = (addr[7:4] == BASE_NIB);
  assign off_s = addr[3:0];
  assign wr_s  = !w_en_n && sel_s;
  assign rd_s  = !r_en_n && sel_s;
  assign unused_s = ^addr[15:8];

  // Out-of-range values are dropped entirely, including the prescaler clear.
  assign hour_wr_s = wr_s && (off_s == RTC_HOUR) && in_range(wdata, HOUR_MAX);
  assign min_wr_s  = wr_s && (off_s == RTC_MIN)  && in_range(wdata, MIN_MAX);
  assign sec_wr_s  = wr_s && (off_s == RTC_SEC)  && in_range(wdata, SEC_MAX);
  assign ctrl_wr_s = wr_s && (off_s == RTC_CTRL);

  rtc_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
    .clock (clock),
    .rst   (rst),
    .en    (run_r),
    .clr   (sec_wr_s),
    .tick  (tick_s)
  );

  // Next time value: an accepted time write overrides the tick for all fields.
  always_comb begin
    hour_nxt_s   = hour_r;
    minute_nxt_s = minute_r;
    second_nxt_s = second_r;
    if (hour_wr_s) begin
      hour_nxt_s = wdata[4:0];
    end else if (min_wr_s) begin
      minute_nxt_s = wdata[5:0];
    end else if (sec_wr_s) begin
      second_nxt_s = wdata[5:0];
    end else if (tick_s) begin
      if ({2'b00, second_r} == SEC_MAX) begin
        second_nxt_s = 6'd0;
        if ({2'b00, minute_r} == MIN_MAX) begin
          minute_nxt_s = 6'd0;
          if ({3'b000, hour_r} == HOUR_MAX) begin
            hour_nxt_s = 5'd0;
          end else begin
            hour_nxt_s = hour_r + 5'd1;
          end
        end else begin
          minute_nxt_s = minute_r + 6'd1;
        end
      end else begin
        second_nxt_s = second_r + 6'd1;
      end
    end else begin
      second_nxt_s = second_r;
    end
  end

  // Time, run control and the registered second pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hour_r     <= 5'd0;
      minute_r   <= 6'd0;
      second_r   <= 6'd0;
      run_r      <= 1'b1;
      sec_tick_r <= 1'b0;
    end else begin
      hour_r     <= hour_nxt_s;
      minute_r   <= minute_nxt_s;
      second_r   <= second_nxt_s;
      sec_tick_r <= tick_s;
      if (ctrl_wr_s) begin
        run_r <= wdata[CTRL_RUN_BIT];
      end
    end
  end

`ifdef RTC_TIMER_ALARM_EN
  logic [4:0] alm_hour_r;
  logic [5:0] alm_min_r;
  logic       alm_en_r, alm_flag_r, alarm_irq_r;
  logic       alm_h_wr_s, alm_m_wr_s, time_wr_s, alarm_hit_s;

  assign alm_h_wr_s = wr_s && (off_s == RTC_ALM_HOUR) && in_range(wdata, HOUR_MAX);
  assign alm_m_wr_s = wr_s && (off_s == RTC_ALM_MIN)  && in_range(wdata, MIN_MAX);
  assign time_wr_s  = hour_wr_s || min_wr_s || sec_wr_s;
  // Only a real advance can fire; a time write landing on the alarm does not.
  assign alarm_hit_s = tick_s && !time_wr_s && alm_en_r &&
                       (hour_nxt_s == alm_hour_r) && (minute_nxt_s == alm_min_r) &&
                       (second_nxt_s == 6'd0);

  // Alarm registers; a fire in the same cycle as a W1C clear keeps the flag set.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      alm_hour_r  <= 5'd0;
      alm_min_r   <= 6'd0;
      alm_en_r    <= 1'b0;
      alm_flag_r  <= 1'b0;
      alarm_irq_r <= 1'b0;
    end else begin
      alarm_irq_r <= alarm_hit_s;
      if (alm_h_wr_s) begin
        alm_hour_r <= wdata[4:0];
      end
      if (alm_m_wr_s) begin
        alm_min_r <= wdata[5:0];
      end
      if (ctrl_wr_s) begin
        alm_en_r <= wdata[CTRL_ALM_EN_BIT];
      end
      if (alarm_hit_s) begin
        alm_flag_r <= 1'b1;
      end else if (ctrl_wr_s && wdata[CTRL_ALM_FLAG_BIT]) begin
        alm_flag_r <= 1'b0;
      end
    end
  end

  assign alarm_irq = alarm_irq_r;
`else
  assign alarm_irq = 1'b0;
`endif

  // Read mux on pre-write register values.
  always_comb begin
    rd_val_s = 8'h00;
    case (off_s)
      RTC_HOUR: rd_val_s = {3'b000, hour_r};
      RTC_MIN:  rd_val_s = {2'b00, minute_r};
      RTC_SEC:  rd_val_s = {2'b00, second_r};
`ifdef RTC_TIMER_ALARM_EN
      RTC_ALM_HOUR: rd_val_s = {3'b000, alm_hour_r};
      RTC_ALM_MIN:  rd_val_s = {2'b00, alm_min_r};
      RTC_CTRL:     rd_val_s = {5'b00000, alm_flag_r, alm_en_r, run_r};
`else
      RTC_CTRL:     rd_val_s = {7'b0000000, run_r};
`endif
      default:  rd_val_s = 8'h00;
    endcase
  end

  // Registered read data, held while no read is addressed to this block.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rdata_r <= 8'h00;
    end else if (rd_s) begin
      rdata_r <= rd_val_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata    = rdata_r;
  assign hour     = hour_r;
  assign minute   = minute_r;
  assign second   = second_r;
  assign sec_tick = sec_tick_r;

endmodule
